i2c_controller: RTL and testbench



---
 rtl/i2c_controller_if.sv | 11 +
 rtl/i2c_controller.sv | 120 ++++++++++++
 tb/tb_i2c_controller.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_controller_if.sv
// Request-side handshake between a configuration sequencer and i2c_controller:
// the 24-bit frame, the GO/END level handshake and per-byte ACK status.
interface i2c_controller_if;
  logic [23:0] i2c_data;
  logic        go;
  logic        i2c_end;
  logic [2:0]  ack;

  modport master (output i2c_data, output go, input i2c_end, input ack);
  modport slave  (input i2c_data, input go, output i2c_end, output ack);
endinterface

// File: rtl/i2c_controller.sv
// Single-master write-only I2C engine: START, three bytes each with an ACK slot, STOP.
// Define I2C_NACK_ABORT_EN to jump straight to the STOP sequence on any NACK.
module i2c_controller (
  input  logic            clk_i2c,
  input  logic            reset_n,
  i2c_controller_if.slave req,
  output logic            i2c_sclk,
  inout  wire             i2c_sdat
);

  localparam logic [5:0] CNT_START    = 6'd1;
  localparam logic [5:0] CNT_LAST_BIT = 6'd55;
  localparam logic [5:0] CNT_ACK_ADDR = 6'd19;
  localparam logic [5:0] CNT_ACK_SUB  = 6'd37;
  localparam logic [5:0] CNT_ACK_DATA = 6'd55;
  localparam logic [5:0] CNT_PRE_STOP = 6'd56;
  localparam logic [5:0] CNT_SCL_UP   = 6'd57;
  localparam logic [5:0] CNT_STOP     = 6'd58;

  logic [5:0]  cnt, cnt_nxt;
  logic [23:0] frame_q;
  logic        sda_low;
  logic        end_q;
  logic [2:0]  ack_q;
  logic        sda_in;
  logic        sclk_nxt, sda_low_nxt, end_nxt;
  logic [4:0]  slot, bit_pos, bit_idx;
  logic [1:0]  byte_sel;

  // Open-drain: the only driven level is 0; a 1 comes from the bus pull-up.
  assign i2c_sdat    = sda_low ? 1'b0 : 1'bz;
  assign sda_in      = i2c_sdat;
  assign req.i2c_end = end_q;
  assign req.ack     = ack_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    cnt_nxt = cnt;
    if (!req.go)
      cnt_nxt = '0;
    else if (cnt != CNT_STOP)
      cnt_nxt = cnt + 6'd1;
`ifdef I2C_NACK_ABORT_EN
    if (req.go && sda_in &&
        (cnt == CNT_ACK_ADDR || cnt == CNT_ACK_SUB || cnt == CNT_ACK_DATA))
      cnt_nxt = CNT_PRE_STOP;
`endif
  end

  // Outputs are decoded from the step being entered, so they are registered alongside cnt.
  always_comb begin
    sclk_nxt    = 1'b1;
    sda_low_nxt = 1'b0;
    end_nxt     = 1'b0;
    slot        = 5'((cnt_nxt - 6'd2) >> 1);
    if (slot < 5'd9) begin
      byte_sel = 2'd0;
      bit_pos  = slot;
    end else if (slot < 5'd18) begin
      byte_sel = 2'd1;
      bit_pos  = slot - 5'd9;
    end else begin
      byte_sel = 2'd2;
      bit_pos  = slot - 5'd18;
    end
    bit_idx = 5'd23 - {byte_sel, 3'b000} - bit_pos;

    if (cnt_nxt == CNT_START) begin
      sda_low_nxt = 1'b1;
    end else if (cnt_nxt >= 6'd2 && cnt_nxt <= CNT_LAST_BIT) begin
      sclk_nxt = cnt_nxt[0];
      // Bit position 8 within a byte is the ACK slot, where SDA stays released.
      if (bit_pos != 5'd8)
        sda_low_nxt = ~frame_q[bit_idx];
    end else if (cnt_nxt == CNT_PRE_STOP) begin
      sclk_nxt    = 1'b0;
      sda_low_nxt = 1'b1;
    end else if (cnt_nxt == CNT_SCL_UP) begin
      sda_low_nxt = 1'b1;
    end else if (cnt_nxt == CNT_STOP) begin
      end_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      frame_q  <= '0;
      i2c_sclk <= 1'b1;
      sda_low  <= 1'b0;
      end_q    <= 1'b0;
      ack_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      cnt      <= cnt_nxt;
      i2c_sclk <= sclk_nxt;
      sda_low  <= sda_low_nxt;
      end_q    <= end_nxt;
      if (cnt == '0 && cnt_nxt == CNT_START)
        frame_q <= req.i2c_data;
      if (!req.go) begin
        ack_q <= '0;
      end else begin
        case (cnt)
`ifdef I2C_NACK_ABORT_EN
          // A NACK here also marks every byte that will not be sent.
          CNT_ACK_ADDR: ack_q      <= {3{sda_in}};
          CNT_ACK_SUB:  ack_q[1:0] <= {2{sda_in}};
`else
          CNT_ACK_ADDR: ack_q[2]   <= sda_in;
          CNT_ACK_SUB:  ack_q[1]   <= sda_in;
`endif
          CNT_ACK_DATA: ack_q[0]   <= sda_in;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Self-checking bench for i2c_controller: randomized frames and slave ACK patterns
// compared edge by edge against a frame-level model of the bus sequence.
module tb_i2c_controller;

  localparam int MODE_NONE  = 0;
  localparam int MODE_RESET = 1;
  localparam int MODE_DROP  = 2;
  localparam int MODE_DATA  = 3;

  logic clk_i2c = 1'b0;
  logic reset_n = 1'b0;
  logic i2c_sclk;
  logic slave_drive = 1'b0;
  wire  sda_bus;

  int checks = 0;
  int errors = 0;

  // Expected bus state after each edge of a frame (index = edge - 1).
  logic       exp_sclk[$];
  logic       exp_sda[$];
  logic       exp_slave[$];
  int         end_edge;
  int         exp_pulses;
  logic [2:0] exp_ack;

  always #5 clk_i2c = ~clk_i2c;

  i2c_controller_if bus_if ();

  assign sda_bus = slave_drive ? 1'b0 : 1'bz;
  pullup pu_sda (sda_bus);

  i2c_controller dut (
    .clk_i2c  (clk_i2c),
    .reset_n  (reset_n),
    .req      (bus_if),
    .i2c_sclk (i2c_sclk),
    .i2c_sdat (sda_bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_step(input logic sclk, input logic sda, input logic slv);
    exp_sclk.push_back(sclk);
    exp_sda.push_back(sda);
    exp_slave.push_back(slv);
  endtask

  // Frame-level model: START, three bytes MSB first each followed by an ACK slot, STOP.
  task automatic build_model(input logic [23:0] frame, input logic [2:0] slave_ack);
    logic [7:0] byte_v;
    logic       acked;
    bit         aborted;
    exp_sclk.delete();
    exp_sda.delete();
    exp_slave.delete();
    exp_ack    = 3'b000;
    exp_pulses = 0;
    aborted    = 0;
    push_step(1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      if (aborted) begin
        exp_ack[2-b] = 1'b1;
      end else begin
        byte_v = frame[23-8*b -: 8];
        for (int i = 7; i >= 0; i--) begin
          push_step(1'b0, byte_v[i], 1'b0);
          push_step(1'b1, byte_v[i], 1'b0);
        end
        acked = slave_ack[2-b];
        push_step(1'b0, ~acked, acked);
        push_step(1'b1, ~acked, acked);
        exp_ack[2-b] = ~acked;
        exp_pulses += 9;
`ifdef I2C_NACK_ABORT_EN
        if (!acked) aborted = 1;
`endif
      end
    end
    push_step(1'b0, 1'b0, 1'b0);
    push_step(1'b1, 1'b0, 1'b0);
    push_step(1'b1, 1'b1, 1'b0);
    end_edge = exp_sclk.size();
  endtask

  task automatic check_idle(input string tag);
    check({tag, " sclk"}, 32'(i2c_sclk), 32'(1));
    check({tag, " sda"},  32'(sda_bus), 32'(1));
    check({tag, " end"},  32'(bus_if.i2c_end), 32'(0));
    check({tag, " ack"},  32'(bus_if.ack), 32'(0));
  endtask

  // Called at negedge+1 with GO low; returns at negedge+1 with GO low again.
  task automatic run_frame(input logic [23:0] frame, input logic [2:0] slave_ack,
                           input int mode, input string name);
    int   pulses;
    logic prev_sclk;
    build_model(frame, slave_ack);
    bus_if.i2c_data = frame;
    bus_if.go       = 1'b1;
    pulses          = 0;
    prev_sclk       = 1'b1;
    for (int e = 1; e <= end_edge; e++) begin
      @(posedge clk_i2c);
      @(negedge clk_i2c);
      slave_drive = exp_slave[e-1];
      #1;
      check($sformatf("%s sclk@%0d", name, e), 32'(i2c_sclk), 32'(exp_sclk[e-1]));
      check($sformatf("%s sda@%0d", name, e),  32'(sda_bus), 32'(exp_sda[e-1]));
      check($sformatf("%s end@%0d", name, e),  32'(bus_if.i2c_end), 32'(e == end_edge));
      if (e < end_edge - 2 && i2c_sclk && !prev_sclk) pulses++;
      prev_sclk = i2c_sclk;
      if (mode == MODE_DATA && e == 10)
        bus_if.i2c_data = frame ^ 24'hA5C3_FF;
      if (mode == MODE_RESET && e == 30) begin
        reset_n     = 1'b0;
        bus_if.go   = 1'b0;
        slave_drive = 1'b0;
        #1;
        check_idle({name, " async reset"});
        @(negedge clk_i2c);
        reset_n = 1'b1;
        @(negedge clk_i2c);
        #1;
        check_idle({name, " after reset"});
        return;
      end
      if (mode == MODE_DROP && e == 30) begin
        bus_if.go   = 1'b0;
        slave_drive = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_i2c);
          #1;
          check_idle($sformatf("%s dropped+%0d", name, i));
        end
        return;
      end
    end
    check({name, " sclk pulses"}, 32'(pulses), 32'(exp_pulses));
    check({name, " ack"}, 32'(bus_if.ack), 32'(exp_ack));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i2c);
      #1;
      check($sformatf("%s hold end+%0d", name, i), 32'(bus_if.i2c_end), 32'(1));
      check($sformatf("%s hold sda+%0d", name, i), 32'(sda_bus), 32'(1));
      check($sformatf("%s hold ack+%0d", name, i), 32'(bus_if.ack), 32'(exp_ack));
    end
    bus_if.go   = 1'b0;
    slave_drive = 1'b0;
    @(negedge clk_i2c);
    #1;
    check_idle({name, " go low"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.go       = 1'b0;
    bus_if.i2c_data = '0;
    repeat (3) @(negedge clk_i2c);
    #1;
    check_idle("reset");
    reset_n = 1'b1;
    @(negedge clk_i2c);
    #1;
    check_idle("post reset");

    run_frame(24'h34_1E_00, 3'b111, MODE_NONE,  "normal");
    run_frame(24'($urandom), 3'b000, MODE_NONE, "no slave");
    run_frame(24'h34_0E_01, 3'b111, MODE_NONE,  "restart");
    run_frame(24'($urandom), 3'b111, MODE_RESET, "reset abort");
    run_frame(24'($urandom), 3'b111, MODE_DROP,  "go abort");
    run_frame(24'h5A_0F_C3, 3'b111, MODE_DATA,  "latch");
    run_frame(24'($urandom), 3'b011, MODE_NONE, "addr nack");
    run_frame(24'($urandom), 3'b101, MODE_NONE, "sub nack");

    for (int n = 0; n < 12; n++)
      run_frame(24'($urandom), 3'($urandom), MODE_NONE, $sformatf("rand%0d", n));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
